controlsplitter: RTL

Readback serializer: the inverse of the pipe-in word combiner. It captures a snapshot of a 64-block combined parameter bus (amps, offsets or phase words) and streams it out one 16-bit word per read strobe, block 0 first. It sits between the active parameter registers and an okPipeOut endpoint, so the host can verify exactly what the waveform core is running.

---
 rtl/controlsplitter.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/controlsplitter.sv
//------------------------------------------------------------------------------
// Module      : controlsplitter
// Description : Readback serializer. Snapshots a BLOCKS x WIDTH combined
//               parameter bus on `load` and streams it out one word per
//               `read` strobe, block 0 first, with 1-cycle read latency.
//               Optional feature macro: CONTROLSPLITTER_CHECKSUM_EN appends
//               a WIDTH-bit wrapping checksum word after the last block.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module controlsplitter #(
    parameter int WIDTH  = 16,
    parameter int BLOCKS = 64
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      load,
    input  logic [WIDTH*BLOCKS-1:0]   combinedin,
    input  logic                      read,
    output logic [WIDTH-1:0]          dataout,
    output logic [$clog2(BLOCKS):0]   wordaddress,
    output logic                      empty,
    output logic                      done,
    output logic                      underflow
);

    localparam int AW = $clog2(BLOCKS);

    localparam logic [AW:0] c_addr_one  = (AW+1)'(1);
    localparam logic [AW:0] c_addr_last = (AW+1)'(BLOCKS-1);

`ifdef CONTROLSPLITTER_CHECKSUM_EN
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_SUM    = 2'd2
    } state_t;
`else
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1
    } state_t;
`endif

    state_t                    state_q, state_d;
    logic [WIDTH*BLOCKS-1:0]   snap_q, snap_d;
    logic [WIDTH-1:0]          dataout_q, dataout_d;
    logic [AW:0]               addr_q, addr_d;
    logic                      empty_q, empty_d;
    logic                      done_q, done_d;
    logic                      underflow_q, underflow_d;
`ifdef CONTROLSPLITTER_CHECKSUM_EN
    logic [WIDTH-1:0]          sum_q, sum_d;
`endif

    // Word view of the snapshot so the current block can be picked by index.
    logic [WIDTH-1:0]          w_blocks [BLOCKS];
    logic [WIDTH-1:0]          w_word;

    for (genvar k = 0; k < BLOCKS; k++) begin : g_blk
        assign w_blocks[k] = snap_q[k*WIDTH +: WIDTH];
    end

    assign w_word = w_blocks[addr_q[AW-1:0]];

    // Next-state and output logic; load has priority over read.
    always_comb begin
        state_d     = state_q;
        snap_d      = snap_q;
        dataout_d   = dataout_q;
        addr_d      = addr_q;
        empty_d     = empty_q;
        done_d      = 1'b0;
        underflow_d = underflow_q;
`ifdef CONTROLSPLITTER_CHECKSUM_EN
        sum_d       = sum_q;
`endif
        if (load) begin
            snap_d      = combinedin;
            addr_d      = '0;
            empty_d     = 1'b0;
            underflow_d = 1'b0;
            state_d     = ST_STREAM;
`ifdef CONTROLSPLITTER_CHECKSUM_EN
            sum_d       = '0;
`endif
        end else if (read) begin
            if (empty_q) begin
                underflow_d = 1'b1;
            end else begin
                case (state_q)
                    ST_STREAM: begin
                        dataout_d = w_word;
                        addr_d    = addr_q + c_addr_one;
`ifdef CONTROLSPLITTER_CHECKSUM_EN
                        sum_d     = sum_q + w_word;
`endif
                        if (addr_q == c_addr_last) begin
`ifdef CONTROLSPLITTER_CHECKSUM_EN
                            // Checksum word still owed; stay non-empty.
                            state_d = ST_SUM;
`else
                            state_d = ST_IDLE;
                            empty_d = 1'b1;
                            done_d  = 1'b1;
`endif
                        end
                    end
`ifdef CONTROLSPLITTER_CHECKSUM_EN
                    ST_SUM: begin
                        dataout_d = sum_q;
                        addr_d    = addr_q + c_addr_one;
                        empty_d   = 1'b1;
                        done_d    = 1'b1;
                        state_d   = ST_IDLE;
                    end
`endif
                    default: ;
                endcase
            end
        end
    end

    // State and output registers, asynchronously cleared.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            snap_q      <= '0;
            dataout_q   <= '0;
            addr_q      <= '0;
            empty_q     <= 1'b1;
            done_q      <= 1'b0;
            underflow_q <= 1'b0;
`ifdef CONTROLSPLITTER_CHECKSUM_EN
            sum_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            snap_q      <= snap_d;
            dataout_q   <= dataout_d;
            addr_q      <= addr_d;
            empty_q     <= empty_d;
            done_q      <= done_d;
            underflow_q <= underflow_d;
`ifdef CONTROLSPLITTER_CHECKSUM_EN
            sum_q       <= sum_d;
`endif
        end
    end

    assign dataout     = dataout_q;
    assign wordaddress = addr_q;
    assign empty       = empty_q;
    assign done        = done_q;
    assign underflow   = underflow_q;

endmodule

`default_nettype wire
